// File: rtl/sd_rd_arbiter.sv
// Round-robin arbiter sharing one sd_card sector-read port between NUM_REQ requesters; a grant lasts one sector.
// Latency: req_rd rise -> sd_rstart 2 clk (input sample + registered decision); byte path is combinational.
// Backpressure: none on the byte path; pending requests wait in IDLE, a grant is never preempted.
//
// Ports:
//   clk, rstn                   clock, asynchronous active-low reset
//   req_rd[NUM_REQ]             level read request per requester, held until its req_ack rises
//   req_lba[32*NUM_REQ]         sector number per requester, slice i = [32*i+31:32*i]
//   req_ack/req_done/req_err    registered per-requester ownership / completion pulse / timeout pulse
//   req_strobe/req_addr/req_data  byte stream, strobe gated to the granted requester only
//   grant_id                    index of current/last granted requester
//   sd_rstart/sd_rsector        read command to sd_card (registered)
//   sd_rbusy/sd_rdone/sd_outen/sd_outaddr/sd_outbyte  status and byte stream from sd_card
module sd_rd_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int START_TMO = 4096
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_REQ-1:0]    req_rd,
  input  logic [32*NUM_REQ-1:0] req_lba,
  output logic [NUM_REQ-1:0]    req_ack,
  output logic [NUM_REQ-1:0]    req_done,
  output logic [NUM_REQ-1:0]    req_err,
  output logic [NUM_REQ-1:0]    req_strobe,
  output logic [8:0]            req_addr,
  output logic [7:0]            req_data,
  output logic [1:0]            grant_id,
  output logic                  sd_rstart,
  output logic [31:0]           sd_rsector,
  input  logic                  sd_rbusy,
  input  logic                  sd_rdone,
  input  logic                  sd_outen,
  input  logic [8:0]            sd_outaddr,
  input  logic [7:0]            sd_outbyte
);

  localparam int CW = $clog2(START_TMO);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BUSY  = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_req;
  logic [1:0]           r_last;
  logic [1:0]           r_grant;
  logic [31:0]          r_rsector;
  logic [CW-1:0]        r_cnt;
  logic                 r_rstart;
  logic [NUM_REQ-1:0]   r_ack;
  logic [NUM_REQ-1:0]   r_done;
  logic [NUM_REQ-1:0]   r_err;

  state_t               w_state_nxt;
  logic [1:0]           w_last_nxt;
  logic [1:0]           w_grant_nxt;
  logic [31:0]          w_rsector_nxt;
  logic [CW-1:0]        w_cnt_nxt;
  logic                 w_rstart_nxt;
  logic [NUM_REQ-1:0]   w_ack_nxt;
  logic [NUM_REQ-1:0]   w_done_nxt;
  logic [NUM_REQ-1:0]   w_err_nxt;
  logic [NUM_REQ-1:0]   w_onehot_nxt;
  logic [NUM_REQ-1:0]   w_onehot_cur;

  logic [3:0]           w_req4;
  logic [2:0]           w_sum;
  logic [1:0]           w_pick;
  logic                 w_any;
  logic [31:0]          w_lba [4];

  // Zero-padded views so the arbitration loop can index a fixed 4-slot space for any NUM_REQ.
  assign w_req4 = 4'(r_req);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lba
    if (gi < NUM_REQ) begin : g_on
      assign w_lba[gi] = req_lba[32*gi +: 32];
    end else begin : g_off
      assign w_lba[gi] = '0;
    end
  end

  // Round-robin pick: first pending requester scanning upward from last+1, wrapping mod NUM_REQ.
  // last+k never exceeds 2*NUM_REQ-1, so a single conditional subtract implements the wrap.
  always_comb begin
    w_pick = r_last;
    w_any  = 1'b0;
    w_sum  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_sum = 3'(r_last) + 3'(k);
      if (w_sum >= 3'(NUM_REQ)) begin
        w_sum = w_sum - 3'(NUM_REQ);
      end
      if (!w_any && w_req4[w_sum[1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_sum[1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_last_nxt    = r_last;
    w_grant_nxt   = r_grant;
    w_rsector_nxt = r_rsector;
    w_cnt_nxt     = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt   = S_START;
          w_grant_nxt   = w_pick;
          w_rsector_nxt = w_lba[w_pick];
          w_cnt_nxt     = '0;
        end
      end
      S_START: begin
        // Busy wins over a timeout landing in the same cycle.
        if (sd_rbusy) begin
          w_state_nxt = S_BUSY;
        end else if (r_cnt == CW'(START_TMO - 1)) begin
          w_state_nxt = S_ABORT;
        end else if (r_cnt != '1) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_BUSY: begin
        if (sd_rdone || !sd_rbusy) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE, S_ABORT: begin
        w_state_nxt = S_IDLE;
        w_last_nxt  = r_grant;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Handshake outputs are decoded from the next state so they come straight out of flops.
    w_onehot_nxt = NUM_REQ'(1) << w_grant_nxt;
    w_rstart_nxt = (w_state_nxt == S_START);
    w_ack_nxt    = (w_state_nxt == S_START || w_state_nxt == S_BUSY) ? w_onehot_nxt : '0;
    w_done_nxt   = (w_state_nxt == S_DONE || w_state_nxt == S_ABORT) ? w_onehot_nxt : '0;
    w_err_nxt    = (w_state_nxt == S_ABORT) ? w_onehot_nxt : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_req     <= '0;
      r_last    <= 2'(NUM_REQ - 1);
      r_grant   <= '0;
      r_rsector <= '0;
      r_cnt     <= '0;
      r_rstart  <= 1'b0;
      r_ack     <= '0;
      r_done    <= '0;
      r_err     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_req     <= req_rd;
      r_last    <= w_last_nxt;
      r_grant   <= w_grant_nxt;
      r_rsector <= w_rsector_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rstart  <= w_rstart_nxt;
      r_ack     <= w_ack_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Byte path: only the owner sees strobes, and only while the card is actually transferring.
  assign w_onehot_cur = NUM_REQ'(1) << r_grant;
  assign req_strobe   = (sd_outen && r_state == S_BUSY) ? w_onehot_cur : '0;
  assign req_addr     = sd_outaddr;
  assign req_data     = sd_outbyte;

  assign req_ack    = r_ack;
  assign req_done   = r_done;
  assign req_err    = r_err;
  assign grant_id   = r_grant;
  assign sd_rstart  = r_rstart;
  assign sd_rsector = r_rsector;

endmodule

// File: tb/tb_sd_rd_arbiter.sv
module tb_sd_rd_arbiter;

  localparam int N   = 2;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req_rd;
  logic [32*N-1:0] req_lba;
  logic [N-1:0]    req_ack, req_done, req_err, req_strobe;
  logic [8:0]      req_addr;
  logic [7:0]      req_data;
  logic [1:0]      grant_id;
  logic            sd_rstart;
  logic [31:0]     sd_rsector;
  logic            sd_rbusy, sd_rdone, sd_outen;
  logic [8:0]      sd_outaddr;
  logic [7:0]      sd_outbyte;

  always #5 clk = ~clk;

  sd_rd_arbiter #(.NUM_REQ(N), .START_TMO(TMO)) dut (
    .clk(clk), .rstn(rstn), .req_rd(req_rd), .req_lba(req_lba),
    .req_ack(req_ack), .req_done(req_done), .req_err(req_err), .req_strobe(req_strobe),
    .req_addr(req_addr), .req_data(req_data), .grant_id(grant_id),
    .sd_rstart(sd_rstart), .sd_rsector(sd_rsector), .sd_rbusy(sd_rbusy), .sd_rdone(sd_rdone),
    .sd_outen(sd_outen), .sd_outaddr(sd_outaddr), .sd_outbyte(sd_outbyte)
  );

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [N-1:0] hold;
  bit           card_mute;
  bit           exp_err;
  int           done_cnt = 0;
  int           grant_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] card_byte(input logic [31:0] sec, input logic [8:0] a);
    return 8'(sec * 32'd3) ^ a[7:0] ^ {7'b0, a[8]};
  endfunction

  function automatic logic [31:0] lba_of(input int i);
    return req_lba[32*i +: 32];
  endfunction

  function automatic logic bitof(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic int rr_pick(input int last, input logic [N-1:0] pend);
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (last + k) % N;
      if (bitof(pend, j)) return j;
    end
    return -1;
  endfunction

  task automatic set_lba(input int i, input logic [31:0] v);
    req_lba[32*i +: 32] = v;
  endtask

  // One clock step; requesters not on hold drop req_rd once their ack is seen.
  task automatic tick();
    @(posedge clk);
    #1;
    req_rd = req_rd & ~(req_ack & ~hold);
  endtask

  task automatic wait_dones(input int target, input int budget, input string name);
    int c = 0;
    while (done_cnt < target && c < budget) begin
      tick();
      c++;
    end
    check(name, 64'(done_cnt), 64'(target));
  endtask

  // Fake sd_card: busy a few cycles after rstart, 512 bytes, then rdone with busy falling.
  initial begin
    sd_rbusy = 1'b0; sd_rdone = 1'b0; sd_outen = 1'b0; sd_outaddr = '0; sd_outbyte = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rstn && sd_rstart && !card_mute) begin
        repeat (3) begin @(posedge clk); #1; end
        sd_rbusy = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        for (int a = 0; a < 512 && rstn; a++) begin
          sd_outen   = 1'b1;
          sd_outaddr = 9'(a);
          sd_outbyte = card_byte(sd_rsector, 9'(a));
          @(posedge clk);
          #1;
        end
        sd_outen = 1'b0;
        sd_rbusy = 1'b0;
        if (rstn) begin
          sd_rdone = 1'b1;
          @(posedge clk);
          #1;
          sd_rdone = 1'b0;
        end
      end
    end
  end

  // Transaction-level model: round-robin order from pending requests, byte stream content, completion.
  int           owner  = -1;
  int           last_m = N - 1;
  int           nbytes = 0;
  logic [N-1:0] hist1 = '0;
  logic [N-1:0] hist2 = '0;

  always @(negedge clk) begin
    int e;
    if (!rstn) begin
      check("rst_ack",     64'(req_ack),    64'(0));
      check("rst_done",    64'(req_done),   64'(0));
      check("rst_err",     64'(req_err),    64'(0));
      check("rst_strobe",  64'(req_strobe), 64'(0));
      check("rst_rstart",  64'(sd_rstart),  64'(0));
      check("rst_rsector", 64'(sd_rsector), 64'(0));
      check("rst_grant",   64'(grant_id),   64'(0));
      owner  = -1;
      last_m = N - 1;
      nbytes = 0;
    end else begin
      if (!sd_outen) check("strobe_idle", 64'(req_strobe), 64'(0));
      else begin
        for (int i = 0; i < N; i++)
          if (i != owner) check("strobe_leak", 64'(bitof(req_strobe, i)), 64'(0));
      end
      if (owner >= 0 && bitof(req_strobe, owner)) begin
        check("byte_addr", 64'(req_addr), 64'(nbytes));
        check("byte_data", 64'(req_data), 64'(card_byte(lba_of(owner), 9'(nbytes))));
        nbytes++;
      end
      if (req_done != '0) begin
        if (owner < 0) begin
          check("spurious_done", 64'(req_done), 64'(0));
        end else begin
          check("done_idx",  64'(req_done), 64'(1) << owner);
          check("done_err",  64'(req_err),  exp_err ? (64'(1) << owner) : 64'(0));
          check("done_nbyt", 64'(nbytes),   exp_err ? 64'(0) : 64'(512));
          check("done_ack",  64'(req_ack),  64'(0));
          owner = -1;
          done_cnt++;
        end
      end else begin
        check("err_alone", 64'(req_err), 64'(0));
        if (owner >= 0) begin
          check("ack_hold", 64'(req_ack), 64'(1) << owner);
        end else if (req_ack != '0) begin
          e = rr_pick(last_m, hist2);
          check("grant_ack",     64'(req_ack),    (e < 0) ? 64'(0) : (64'(1) << e));
          check("grant_id",      64'(grant_id),   64'(e));
          check("grant_rstart",  64'(sd_rstart),  64'(1));
          check("grant_rsector", 64'(sd_rsector), (e < 0) ? 64'(0) : 64'(lba_of(e)));
          owner  = (e < 0) ? 0 : e;
          last_m = owner;
          nbytes = 0;
          grant_log.push_back(owner);
        end
      end
    end
    hist2 = hist1;
    hist1 = req_rd;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete (compared %0d)", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int n;
    int base;
    int exp_log[11] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    req_rd = '0; hold = '0; req_lba = '0; card_mute = 1'b0; exp_err = 1'b0; rstn = 1'b0;
    repeat (3) tick();
    check("init_rsector", 64'(sd_rsector), 64'(0));
    check("init_rstart",  64'(sd_rstart),  64'(0));
    check("init_ack",     64'(req_ack),    64'(0));
    rstn = 1'b1;
    repeat (3) tick();

    // 1: single request, 2-clk start latency, full sector to requester 0
    set_lba(0, 32'h0000_0123);
    req_rd = 2'b01;
    tick();
    check("t1_rstart_1clk", 64'(sd_rstart), 64'(0));
    tick();
    check("t1_rstart_2clk", 64'(sd_rstart),  64'(1));
    check("t1_rsector",     64'(sd_rsector), 64'h123);
    check("t1_ack",         64'(req_ack),    64'(2'b01));
    wait_dones(1, 1200, "t1_done");

    // 2: simultaneous requests after reset -> 0 then 1; 0 held through its own done loses to 1
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick();
    set_lba(0, 32'd10);
    set_lba(1, 32'd20);
    req_rd = 2'b11;
    wait_dones(3, 2500, "t2_round1");
    hold[0] = 1'b1;
    req_rd = req_rd | 2'b01;
    c = 0;
    while (!req_ack[0] && c < 50) begin tick(); c++; end
    check("t2_ack0", 64'(req_ack), 64'(2'b01));
    req_rd = req_rd | 2'b10;
    c = 0;
    while (!req_ack[1] && c < 1200) begin tick(); c++; end
    check("t2_ack1_next", 64'(req_ack), 64'(2'b10));
    hold[0] = 1'b0;
    wait_dones(6, 2000, "t2_round2");

    // 5: requester 1 drops req_rd mid-sector -> completes, no re-grant
    set_lba(1, 32'h55);
    hold[1] = 1'b1;
    req_rd = req_rd | 2'b10;
    c = 0;
    while (!req_strobe[1] && c < 100) begin tick(); c++; end
    check("t5_busy", 64'(req_strobe[1]), 64'(1));
    req_rd = req_rd & 2'b01;
    hold[1] = 1'b0;
    wait_dones(7, 1200, "t5_done");
    repeat (20) tick();
    check("t5_no_regrant", 64'(req_ack), 64'(0));
    check("t5_log_size",   64'(grant_log.size()), 64'(7));

    // 3: card never goes busy -> abort on the 16th START cycle, then requester 1 served
    card_mute = 1'b1;
    exp_err   = 1'b1;
    set_lba(0, 32'h30);
    set_lba(1, 32'h31);
    req_rd = 2'b11;
    c = 0;
    while (!sd_rstart && c < 50) begin tick(); c++; end
    check("t3_start_seen", 64'(req_ack), 64'(2'b01));
    n = sd_rstart ? 1 : 0;
    while (sd_rstart && n < 100) begin
      tick();
      if (sd_rstart) n++;
    end
    check("t3_start_cycles", 64'(n),        64'(16));
    check("t3_done",         64'(req_done), 64'(2'b01));
    check("t3_err",          64'(req_err),  64'(2'b01));
    tick();
    card_mute = 1'b0;
    exp_err   = 1'b0;
    wait_dones(9, 1200, "t3_next");

    // 4: reset at byte 200 -> outputs clear at once, no done, pending requester 1 then served
    set_lba(0, 32'h40);
    set_lba(1, 32'h41);
    req_rd = 2'b01;
    c = 0;
    while (!req_ack[0] && c < 50) begin tick(); c++; end
    req_rd = req_rd | 2'b10;
    c = 0;
    while (!(req_strobe[0] && req_addr == 9'd200) && c < 300) begin tick(); c++; end
    check("t4_at_byte200", 64'(req_addr), 64'(200));
    base = done_cnt;
    rstn = 1'b0;
    #1;
    check("t4_rst_ack",     64'(req_ack),    64'(0));
    check("t4_rst_rstart",  64'(sd_rstart),  64'(0));
    check("t4_rst_rsector", 64'(sd_rsector), 64'(0));
    check("t4_rst_strobe",  64'(req_strobe), 64'(0));
    check("t4_rst_grant",   64'(grant_id),   64'(0));
    check("t4_rst_done",    64'(req_done),   64'(0));
    repeat (3) tick();
    check("t4_no_done", 64'(done_cnt), 64'(base));
    rstn = 1'b1;
    wait_dones(base + 1, 1200, "t4_regrant");
    check("t4_grant1", 64'(grant_log[grant_log.size()-1]), 64'(1));

    // req_rd pulse that never meets a clock edge -> nothing happens
    repeat (5) tick();
    n = grant_log.size();
    req_rd = 2'b01;
    #2;
    req_rd = 2'b00;
    repeat (10) tick();
    check("glitch_no_ack", 64'(req_ack), 64'(0));
    check("glitch_log",    64'(grant_log.size()), 64'(n));

    check("log_size", 64'(grant_log.size()), 64'(11));
    for (int i = 0; i < 11 && i < grant_log.size(); i++)
      check($sformatf("log_%0d", i), 64'(grant_log[i]), 64'(exp_log[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
